hack_vector_checker: RTL and testbench
======================================

Name: hack_vector_checker

Overview:
Synthesizable, parametrised vector-driven checker for Hack CPU (or any single-clock DUT) regression on FPGA. Holds stimulus/expected/mask vectors in internal RAM loaded through a write port. Applies one vector per step, pulses the DUT clock-enable, waits a settle window and compares the DUT outputs under a per-bit mask. Reports pass/fail, saturating error count and first failing index; optional halt-on-first-fail mode.

Parameters:
STIM_W, 33, stimulus width (default {inM[15:0], instruction[15:0], reset})
CHK_W, 47, checked-output width (default {outM[15:0], writeM, addressM[14:0], pc[14:0]})
DEPTH, 128, vector RAM entries
AW, 7, address width, 2**AW >= DEPTH
SETTLE, 1, wait cycles between dut_step and compare (0 legal)
CNT_W, 8, error counter width
HALT_ON_FAIL, 0, 1 = stop at first mismatching vector
(derived) VEC_W = STIM_W + 2*CHK_W; vector layout {stim, exp, mask}, mask bit 1 = compare

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high
wr_en  in  1  vector RAM write strobe
wr_addr  in  AW  RAM write address
wr_data  in  VEC_W  vector word
num_vec  in  AW+1  vectors to run (0..DEPTH), sampled on start
start  in  1  one-cycle run request
dut_obs  in  CHK_W  DUT outputs, packed as exp field
stim_out  out  STIM_W  registered stimulus to DUT
dut_step  out  1  one-cycle DUT clock-enable pulse
busy  out  1  run in progress
done  out  1  run finished, held until next accepted start
pass  out  1  valid when done: err_count==0
err_count  out  CNT_W  mismatching vectors, saturates at all-ones
first_fail_valid  out  1  a mismatch has been recorded this run
first_fail_idx  out  AW  index of first mismatching vector
cur_idx  out  AW  vector currently in flight
diff_bits  out  CHK_W  (exp ^ dut_obs) & mask of most recent mismatch

Behaviour:
- Reset: all outputs 0, FSM IDLE; RAM contents NOT cleared. Reset mid-run aborts immediately, no done.
- RAM: synchronous write, synchronous read (1-cycle latency). Writes accepted only when busy==0; ignored while busy.
- start accepted only in IDLE or DONE; ignored while busy. Accept clears done, pass, err_count, first_fail_*, diff_bits, cur_idx; latches num_vec; busy=1 next cycle.
- num_vec==0: FSM goes straight to DONE; one cycle after start: done=1, pass=1, busy=0.
- num_vec>DEPTH: clamped to DEPTH.
- FSM: IDLE -> FETCH (read addr=cur_idx) -> APPLY (stim_out <= stim field; dut_step=1 this cycle only) -> WAIT (SETTLE cycles; skipped if SETTLE==0) -> CHECK -> FETCH or DONE.
- Per-vector cost: SETTLE+3 cycles; stim_out stable from APPLY until next APPLY.
- CHECK: mismatch = |((dut_obs ^ exp) & mask). On mismatch: err_count+1 (saturating), diff_bits updated; if first_fail_valid==0, capture cur_idx and set first_fail_valid.
- After CHECK: if cur_idx==num_vec-1, or (HALT_ON_FAIL and mismatch) -> DONE; else cur_idx+1 -> FETCH.
- DONE: busy=0, done=1, pass=(err_count==0); cur_idx holds last checked index.
- Mask all-zero vector always passes (stimulus-only step).

Test Plan:
- Load 4 vectors, all exp==dut_obs model, SETTLE=1, num_vec=4 -> 4 dut_step pulses 4 cycles apart; done at start+17; pass=1, err_count=0, first_fail_valid=0.
- Vectors 1 and 3 expect pc=0x0005, DUT returns 0x0004 -> err_count=2, first_fail_idx=1, diff_bits=0x1, pass=0.
- Same as above with HALT_ON_FAIL=1 -> done after vector 1, cur_idx=1, err_count=1, exactly 2 dut_step pulses.
- Mismatch confined to masked-off bits (mask=0x7FFF_0000_0000 region cleared) -> pass=1.
- num_vec=0 -> done=1, pass=1 one cycle after start, zero dut_step pulses; start and wr_en asserted while busy -> ignored, RAM unchanged.
- Assert reset during vector 2 of 4 -> next cycle busy=0, done=0, counters 0; re-run start -> full 4-vector run using retained RAM, pass=1; CNT_W=2 with 5 failing vectors -> err_count=3.

Source files
------------

// File: rtl/hack_vector_checker.sv
// Vector-driven regression checker: replays stimulus from internal RAM, steps the DUT, compares masked outputs.
// Per vector: FETCH, APPLY (dut_step), SETTLE wait cycles, CHECK = SETTLE+3 cycles; start/writes ignored while busy.
module hack_vector_checker #(
  parameter int STIM_W       = 33,
  parameter int CHK_W        = 47,
  parameter int DEPTH        = 128,
  parameter int AW           = 7,
  parameter int SETTLE       = 1,
  parameter int CNT_W        = 8,
  parameter int HALT_ON_FAIL = 0,
  localparam int VEC_W       = STIM_W + 2 * CHK_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [VEC_W-1:0]  wr_data,
  input  logic [AW:0]       num_vec,
  input  logic              start,
  input  logic [CHK_W-1:0]  dut_obs,
  output logic [STIM_W-1:0] stim_out,
  output logic              dut_step,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_count,
  output logic              first_fail_valid,
  output logic [AW-1:0]     first_fail_idx,
  output logic [AW-1:0]     cur_idx,
  output logic [CHK_W-1:0]  diff_bits
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_APPLY, S_WAIT, S_CHECK, S_DONE
  } state_t;

  localparam int WCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [AW:0] DEPTH_N = (AW + 1)'(DEPTH);

  logic [VEC_W-1:0] mem [DEPTH];
  state_t           state, state_nx;
  logic [CHK_W-1:0] exp_q, mask_q, diff_now;
  logic [AW:0]      n_q;
  logic [WCW-1:0]   wait_cnt;
  logic             accept, mismatch, last_vec;

  assign accept   = start && (state == S_IDLE || state == S_DONE);
  assign diff_now = (dut_obs ^ exp_q) & mask_q;
  assign mismatch = |diff_now;
  assign last_vec = ({1'b0, cur_idx} == n_q - 1'b1);
  assign pass     = done && (err_count == '0);

  // RAM contents deliberately survive reset so a run can be repeated without reloading.
  always_ff @(posedge clk) begin
    if (wr_en && !busy && int'(wr_addr) < DEPTH)
      mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    dut_step = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        done = (state == S_DONE);
        if (accept) state_nx = (num_vec == '0) ? S_DONE : S_FETCH;
      end
      S_FETCH: begin
        busy     = 1'b1;
        state_nx = S_APPLY;
      end
      S_APPLY: begin
        busy     = 1'b1;
        dut_step = 1'b1;
        state_nx = (SETTLE == 0) ? S_CHECK : S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (int'(wait_cnt) >= SETTLE - 1) state_nx = S_CHECK;
      end
      S_CHECK: begin
        busy     = 1'b1;
        state_nx = (last_vec || (HALT_ON_FAIL != 0 && mismatch)) ? S_DONE : S_FETCH;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stim_out         <= '0;
      exp_q            <= '0;
      mask_q           <= '0;
      n_q              <= '0;
      wait_cnt         <= '0;
      cur_idx          <= '0;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_idx   <= '0;
      diff_bits        <= '0;
    end else begin
      if (accept) begin
        n_q              <= (num_vec > DEPTH_N) ? DEPTH_N : num_vec;
        cur_idx          <= '0;
        err_count        <= '0;
        first_fail_valid <= 1'b0;
        first_fail_idx   <= '0;
        diff_bits        <= '0;
      end
      case (state)
        // Stimulus lands at the start of APPLY so the DUT sees it together with dut_step.
        S_FETCH: {stim_out, exp_q, mask_q} <= mem[cur_idx];
        S_APPLY: wait_cnt <= '0;
        S_WAIT:  wait_cnt <= wait_cnt + 1'b1;
        S_CHECK: begin
          if (mismatch) begin
            if (err_count != {CNT_W{1'b1}}) err_count <= err_count + 1'b1;
            diff_bits <= diff_now;
            if (!first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_idx   <= cur_idx;
            end
          end
          if (state_nx == S_FETCH) cur_idx <= cur_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hack_vector_checker.sv
// Bench for hack_vector_checker: three parameter variants driven in parallel against a small registered DUT model.
module tb_hack_vector_checker;
  localparam int STIM_W = 33;
  localparam int CHK_W  = 47;
  localparam int DEPTH  = 128;
  localparam int AW     = 7;
  localparam int VEC_W  = STIM_W + 2 * CHK_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, wr_en, start;
  logic [AW-1:0]     wr_addr;
  logic [VEC_W-1:0]  wr_data;
  logic [AW:0]       num_vec;

  logic [CHK_W-1:0]  obs0 = '0, obs1 = '0, obs2 = '0;
  logic [STIM_W-1:0] stim0, stim1, stim2;
  logic              step0, step1, step2, busy0, busy1, busy2, done0, done1, done2;
  logic              pass0, pass1, pass2, ffv0, ffv1, ffv2;
  logic [7:0]        err0, err1;
  logic [1:0]        err2;
  logic [AW-1:0]     ffi0, ffi1, ffi2, cur0, cur1, cur2;
  logic [CHK_W-1:0]  diff0, diff1, diff2;

  hack_vector_checker u0 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .num_vec(num_vec), .start(start), .dut_obs(obs0), .stim_out(stim0), .dut_step(step0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .first_fail_valid(ffv0),
    .first_fail_idx(ffi0), .cur_idx(cur0), .diff_bits(diff0));

  hack_vector_checker #(.SETTLE(0), .HALT_ON_FAIL(1)) u1 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .num_vec(num_vec), .start(start), .dut_obs(obs1), .stim_out(stim1), .dut_step(step1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .first_fail_valid(ffv1),
    .first_fail_idx(ffi1), .cur_idx(cur1), .diff_bits(diff1));

  hack_vector_checker #(.SETTLE(2), .CNT_W(2)) u2 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .num_vec(num_vec), .start(start), .dut_obs(obs2), .stim_out(stim2), .dut_step(step2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .first_fail_valid(ffv2),
    .first_fail_idx(ffi2), .cur_idx(cur2), .diff_bits(diff2));

  // Toy single-clock DUT: outputs are a fixed rearrangement of the stimulus, updated on dut_step.
  function automatic logic [CHK_W-1:0] model(input logic [STIM_W-1:0] s);
    return {s[32:17], s[0], s[31:17], s[15:1]};
  endfunction

  always @(posedge clk) begin
    if (step0) obs0 <= model(stim0);
    if (step1) obs1 <= model(stim1);
    if (step2) obs2 <= model(stim2);
  end

  typedef struct {
    int nv; int fail; int mode;
    int err0; int ffv0; int ffi0; int diff0;
    int err1; int cur1; int pulse1;
    int err2;
  } case_t;
  case_t cases [8];

  int n_chk = 0, n_pass = 0;
  logic [STIM_W-1:0] q0 [$];
  logic [STIM_W-1:0] q1 [$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, want);
  endtask

  function automatic logic [STIM_W-1:0] gen_stim(input int c, input int i);
    logic [STIM_W-1:0] s;
    s[32:17] = 16'(i * 37 + c * 1000 + 3);
    s[16:1]  = 16'(i * 2 + 4 + c * 64);
    s[0]     = 1'b0;
    return s;
  endfunction

  function automatic logic [VEC_W-1:0] build(input int c, input int i);
    logic [STIM_W-1:0] s;
    logic [CHK_W-1:0]  e, m;
    bit                bad;
    s   = gen_stim(c, i);
    e   = model(s);
    m   = '1;
    bad = (i < 32) && (((cases[c].fail >> i) & 1) != 0);
    case (cases[c].mode)
      1: begin
        m = 47'h0000_FFFF_FFFF;
        if (bad) e = e ^ 47'h1234_0000_0000;
      end
      2: begin
        m = '0;
        if (bad) e = e ^ 47'h1;
      end
      default: if (bad) e = e ^ 47'h1;
    endcase
    return {s, e, m};
  endfunction

  // Scoreboard: each dut_step must carry the next expected stimulus word.
  always @(negedge clk) begin
    if (step0) begin
      if (q0.size() == 0) check("sb0_extra_step", 1, 0);
      else check("sb0_stim", stim0, q0.pop_front());
    end
    if (step1) begin
      if (q1.size() == 0) check("sb1_extra_step", 1, 0);
      else check("sb1_stim", stim1, q1.pop_front());
    end
  end

  task automatic load(input int c, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = build(c, i);
      @(negedge clk);
    end
    wr_en = 1'b0;
  endtask

  task automatic fill_queues(input int c);
    int nc;
    nc = (cases[c].nv > DEPTH) ? DEPTH : cases[c].nv;
    q0.delete(); q1.delete();
    for (int i = 0; i < nc; i++) q0.push_back(gen_stim(c, i));
    for (int i = 0; i < cases[c].pulse1; i++) q1.push_back(gen_stim(c, i));
  endtask

  task automatic wait_all_done(input int limit);
    int t = 0;
    while (!(done0 && done1 && done2) && t < limit) begin
      @(negedge clk);
      t++;
    end
    check("run_done", {61'b0, done0, done1, done2}, 64'h7);
  endtask

  task automatic check_results(input int c);
    int nc;
    nc = (cases[c].nv > DEPTH) ? DEPTH : cases[c].nv;
    check("u0_busy",  busy0, 0);
    check("u0_pass",  pass0, cases[c].err0 == 0);
    check("u0_err",   err0,  cases[c].err0);
    check("u0_ffv",   ffv0,  cases[c].ffv0);
    check("u0_ffi",   ffi0,  cases[c].ffi0);
    check("u0_diff",  diff0, cases[c].diff0);
    check("u0_cur",   cur0,  (nc == 0) ? 0 : nc - 1);
    check("u0_steps_left", q0.size(), 0);
    check("u1_err",   err1,  cases[c].err1);
    check("u1_cur",   cur1,  cases[c].cur1);
    check("u1_pass",  pass1, cases[c].err1 == 0);
    check("u1_steps_left", q1.size(), 0);
    check("u2_err",   err2,  cases[c].err2);
    check("u2_pass",  pass2, cases[c].err2 == 0);
  endtask

  task automatic run_case(input int c, input bit do_load);
    if (do_load) load(c, (cases[c].nv > DEPTH) ? DEPTH : cases[c].nv);
    fill_queues(c);
    num_vec = (AW + 1)'(cases[c].nv);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (cases[c].nv == 0) begin
      check("nv0_done_next_cycle", done0, 1);
      check("nv0_pass_next_cycle", pass0, 1);
    end else begin
      check("start_clears_done", done0, 0);
      check("start_sets_busy", busy0, 1);
    end
    wait_all_done(2000);
    check_results(c);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cases[0] = '{4,   0,  0, 0, 0, 0, 0, 0, 3,   4,   0};
    cases[1] = '{4,   10, 0, 2, 1, 1, 1, 1, 1,   2,   2};
    cases[2] = '{4,   10, 1, 0, 0, 0, 0, 0, 3,   4,   0};
    cases[3] = '{5,   31, 0, 5, 1, 0, 1, 1, 0,   1,   3};
    cases[4] = '{0,   0,  0, 0, 0, 0, 0, 0, 0,   0,   0};
    cases[5] = '{3,   7,  2, 0, 0, 0, 0, 0, 2,   3,   0};
    cases[6] = '{200, 0,  0, 0, 0, 0, 0, 0, 127, 128, 0};
    cases[7] = '{4,   8,  0, 1, 1, 3, 1, 1, 3,   4,   1};

    reset = 1'b1; wr_en = 1'b0; start = 1'b0; num_vec = '0; wr_addr = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_pass", pass0, 0);
    check("rst_err",  err0,  0);
    check("rst_stim", stim0, 0);
    check("rst_step", step0, 0);
    check("rst_ffv",  ffv0,  0);
    check("rst_diff", diff0, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int c = 0; c < 8; c++) run_case(c, 1'b1);

    // Exact cycle timing of a 4-vector run, with start and a RAM write poked in mid-run.
    load(0, 4);
    fill_queues(0);
    num_vec = 4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 17; k++) begin
      check("timing_step", step0, (k % 4 == 1) && (k <= 13));
      if (k == 15) check("timing_not_done_yet", done0, 0);
      if (k == 16) check("timing_done", done0, 1);
      if (k == 6) begin
        wr_en = 1'b1; wr_addr = '0; num_vec = '0; start = 1'b1;
        wr_data = {gen_stim(0, 0), ~model(gen_stim(0, 0)), {CHK_W{1'b1}}};
      end else begin
        wr_en = 1'b0; start = 1'b0;
      end
      @(negedge clk);
    end
    wait_all_done(2000);
    check_results(0);

    // Replay without reload: the write issued while busy must not have landed.
    run_case(0, 1'b0);

    // Reset in the middle of vector 2, then a clean replay from retained RAM.
    fill_queues(0);
    num_vec = 4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 200 && cur0 != 2; t++) @(negedge clk);
    check("mid_reach_v2", cur0, 2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_busy", busy0, 0);
    check("mid_rst_done", done0, 0);
    check("mid_rst_err",  err0,  0);
    check("mid_rst_cur",  cur0,  0);
    check("mid_rst_stim", stim0, 0);
    check("mid_rst_u2_busy", busy2, 0);
    q0.delete(); q1.delete();
    @(negedge clk);
    run_case(0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
